// File: rtl/seg7_scan_pkg.sv
// Shared definitions for the seg7_scan display controller.
//   state_t   : scan controller states (off, digit lit, inter-digit gap)
//   SEG_OFF   : segment pattern for a dark digit
//   cnt_width : bit width needed to count down from max(a, b)-1 to 0
package seg7_scan_pkg;

  typedef enum logic [1:0] {
    S_OFF,
    S_SHOW,
    S_GAP
  } state_t;

  localparam logic [7:0] SEG_OFF = 8'h00;

  // Counters load with (n-1), so $clog2(n) bits are enough; a zero-width
  // counter is not legal, so the floor is one bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/seg7_scan_if.sv
// Register-side bus of the seg7_scan controller.
//   en       : scan enable, low forces the display off
//   load     : one-cycle strobe capturing value/dp_in/blank_in
//   value    : NUM_DIGITS hex nibbles, digit 0 in the low nibble
//   dp_in    : decimal point per digit
//   blank_in : per-digit force-dark mask
// master = CPU/IO register side, slave = scan controller.
interface seg7_scan_if #(
  parameter int NUM_DIGITS = 4
);

  logic                    en;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_in;

  modport master (output en, load, value, dp_in, blank_in);
  modport slave  (input  en, load, value, dp_in, blank_in);

endinterface

// File: rtl/seg7_scan_seg7.sv
// Hex-to-7-segment decoder shared by all scanned digits.
//   nibble : hex digit 0..F
//   segs   : segments a..g on bits 6..0, active-high
module seg7_scan_seg7 (
  input  logic [3:0] nibble,
  output logic [6:0] segs
);

  // Pure lookup of the glyph for each hex digit; lowercase b and d are used
  // so they cannot be confused with 8 and 0.
  always_comb begin
    segs = 7'b000_0000;
    case (nibble)
      4'h0: segs = 7'b111_1110;
      4'h1: segs = 7'b011_0000;
      4'h2: segs = 7'b110_1101;
      4'h3: segs = 7'b111_1001;
      4'h4: segs = 7'b011_0011;
      4'h5: segs = 7'b101_1011;
      4'h6: segs = 7'b101_1111;
      4'h7: segs = 7'b111_0000;
      4'h8: segs = 7'b111_1111;
      4'h9: segs = 7'b111_1011;
      4'ha: segs = 7'b111_0111;
      4'hb: segs = 7'b001_1111;
      4'hc: segs = 7'b100_1110;
      4'hd: segs = 7'b011_1101;
      4'he: segs = 7'b100_1111;
      4'hf: segs = 7'b100_0111;
      default: segs = 7'b000_0000;
    endcase
  end

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed scan controller for NUM_DIGITS 7-segment digits.
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   bus        : register-side interface (en, load, value, dp_in, blank_in)
//   seg        : segments a..g,dp on bits 7..0, active-high
//   dig        : one-hot digit enable, active-high
//   frame_done : high during the final cycle of each frame
// Each digit is lit for DWELL cycles then dark for GAP cycles. New values
// are held in a pending buffer and only reach the display at frame
// boundaries so a frame never mixes old and new digits.
module seg7_scan
  import seg7_scan_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int DWELL       = 1000,
  parameter int GAP         = 16,
  parameter int LZ_SUPPRESS = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seg7_scan_if.slave            bus,
  output logic [7:0]            seg,
  output logic [NUM_DIGITS-1:0] dig,
  output logic                  frame_done
);

  localparam int CW = cnt_width(DWELL, GAP);
  localparam int IW = cnt_width(NUM_DIGITS, 1);
  localparam logic [CW-1:0] DWELL_LD = CW'(DWELL - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

  state_t                  state, state_nx;
  logic [IW-1:0]           idx, idx_nx;
  logic [CW-1:0]           cnt, cnt_nx;
  logic                    advance, wrap, abort;

  logic [4*NUM_DIGITS-1:0] act_value, pend_value;
  logic [NUM_DIGITS-1:0]   act_dp, pend_dp;
  logic [NUM_DIGITS-1:0]   act_blank, pend_blank;
  logic                    pend_valid;

  logic [NUM_DIGITS-1:0]   lz_mask;
  logic                    zeros_above;
  logic [3:0]              cur_nib;
  logic [6:0]              cur_segs;
  logic                    digit_dark;

  // State register: state, digit index and dwell/gap down-counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_OFF;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state logic. Dropping en from a running state always returns to
  // OFF at digit 0. "advance" moves to the next digit's SHOW; when it
  // leaves the last digit it is the frame boundary (wrap). With GAP = 0
  // SHOW advances directly and the GAP state is never entered.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    cnt_nx   = cnt;
    advance  = 1'b0;
    wrap     = 1'b0;
    abort    = 1'b0;
    case (state)
      S_OFF: begin
        if (bus.en) begin
          state_nx = S_SHOW;
          idx_nx   = '0;
          cnt_nx   = DWELL_LD;
        end
      end
      S_SHOW: begin
        if (!bus.en)
          abort = 1'b1;
        else if (cnt != '0)
          cnt_nx = cnt - CW'(1);
        else if (GAP > 0) begin
          state_nx = S_GAP;
          cnt_nx   = GAP_LD;
        end else
          advance = 1'b1;
      end
      S_GAP: begin
        if (!bus.en)
          abort = 1'b1;
        else if (cnt != '0)
          cnt_nx = cnt - CW'(1);
        else
          advance = 1'b1;
      end
      default: state_nx = S_OFF;
    endcase
    if (advance) begin
      state_nx = S_SHOW;
      cnt_nx   = DWELL_LD;
      if (idx == LAST_IDX) begin
        idx_nx = '0;
        wrap   = 1'b1;
      end else
        idx_nx = idx + IW'(1);
    end
    if (abort) begin
      state_nx = S_OFF;
      idx_nx   = '0;
      cnt_nx   = '0;
    end
  end

  // Display data. While off, loads go straight to the active set. While
  // scanning they are parked in pending, and pending is committed at the
  // frame boundary or when scanning is aborted. A load arriving on the
  // commit edge itself wins over pending so it is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_value  <= '0;
      act_dp     <= '0;
      act_blank  <= '0;
      pend_value <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      pend_valid <= 1'b0;
    end else if (state == S_OFF) begin
      if (bus.load) begin
        act_value <= bus.value;
        act_dp    <= bus.dp_in;
        act_blank <= bus.blank_in;
      end
    end else if (wrap || abort) begin
      if (bus.load) begin
        act_value <= bus.value;
        act_dp    <= bus.dp_in;
        act_blank <= bus.blank_in;
      end else if (pend_valid) begin
        act_value <= pend_value;
        act_dp    <= pend_dp;
        act_blank <= pend_blank;
      end
      pend_valid <= 1'b0;
    end else if (bus.load) begin
      pend_value <= bus.value;
      pend_dp    <= bus.dp_in;
      pend_blank <= bus.blank_in;
      pend_valid <= 1'b1;
    end
  end

  // Leading-zero mask: walking down from the top digit, a digit is dark
  // while every nibble from it upward is zero. Digit 0 is always shown.
  always_comb begin
    lz_mask     = '0;
    zeros_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zeros_above = zeros_above & (act_value[4*i +: 4] == 4'h0);
      if (LZ_SUPPRESS != 0 && i > 0)
        lz_mask[i] = zeros_above;
    end
  end

  assign cur_nib = act_value[4*idx +: 4];

  seg7_scan_seg7 u_dec (
    .nibble (cur_nib),
    .segs   (cur_segs)
  );

  // Outputs decode only registered state, so the pins never glitch on
  // input activity. A dark digit still gets its digit enable so the scan
  // timing seen on the pins is unchanged. frame_done marks the last cycle
  // of the last digit (its last GAP cycle, or last SHOW cycle when GAP = 0).
  always_comb begin
    seg        = SEG_OFF;
    dig        = '0;
    digit_dark = act_blank[idx] | lz_mask[idx];
    if (state == S_SHOW) begin
      dig = NUM_DIGITS'(1) << idx;
      if (!digit_dark)
        seg = {cur_segs, act_dp[idx]};
    end
    frame_done = (idx == LAST_IDX) && (cnt == '0) &&
                 ((GAP > 0) ? (state == S_GAP) : (state == S_SHOW));
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan (NUM_DIGITS=4, DWELL=4, GAP=2).
// Two instances share one bus: dut without and dut_lz with leading-zero
// suppression. A timeline model (frame position t) predicts the outputs.
module tb_seg7_scan;

  localparam int ND    = 4;
  localparam int DW    = 4;
  localparam int GP    = 2;
  localparam int SLOT  = DW + GP;
  localparam int FRAME = ND * SLOT;

  localparam logic [7:0] GLYPH [16] = '{
    8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
    8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
  };

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  seg7_scan_if #(.NUM_DIGITS(ND)) bus ();

  logic [7:0]    seg0, seg1;
  logic [ND-1:0] dig0, dig1;
  logic          fd0, fd1;

  seg7_scan #(.NUM_DIGITS(ND), .DWELL(DW), .GAP(GP), .LZ_SUPPRESS(0)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .seg(seg0), .dig(dig0), .frame_done(fd0)
  );

  seg7_scan #(.NUM_DIGITS(ND), .DWELL(DW), .GAP(GP), .LZ_SUPPRESS(1)) dut_lz (
    .clk(clk), .rst_n(rst_n), .bus(bus), .seg(seg1), .dig(dig1), .frame_done(fd1)
  );

  int checks = 0;
  int errors = 0;

  bit          running = 1'b0;
  int          t = 0;
  logic [15:0] act_v = '0, pend_v = '0;
  logic [3:0]  act_dp = '0, pend_dp = '0, act_bl = '0, pend_bl = '0;
  bit          pv = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic ld, input logic [15:0] v,
                               input logic [3:0] dp, input logic [3:0] bl);
    bus.en       = en;
    bus.load     = ld;
    bus.value    = v;
    bus.dp_in    = dp;
    bus.blank_in = bl;
  endtask

  task automatic modelReset();
    running = 1'b0; t = 0; pv = 1'b0;
    act_v = '0; act_dp = '0; act_bl = '0;
    pend_v = '0; pend_dp = '0; pend_bl = '0;
  endtask

  task automatic commitActive();
    if (bus.load) begin
      act_v = bus.value; act_dp = bus.dp_in; act_bl = bus.blank_in;
    end else if (pv) begin
      act_v = pend_v; act_dp = pend_dp; act_bl = pend_bl;
    end
    pv = 1'b0;
  endtask

  task automatic modelStep();
    if (!rst_n) begin
      modelReset();
    end else if (!running) begin
      if (bus.load) begin
        act_v = bus.value; act_dp = bus.dp_in; act_bl = bus.blank_in;
      end
      if (bus.en) begin
        running = 1'b1; t = 0;
      end
    end else if (!bus.en) begin
      commitActive();
      running = 1'b0; t = 0;
    end else if (t == FRAME - 1) begin
      commitActive();
      t = 0;
    end else begin
      if (bus.load) begin
        pend_v = bus.value; pend_dp = bus.dp_in; pend_bl = bus.blank_in; pv = 1'b1;
      end
      t++;
    end
  endtask

  task automatic expected(input bit lz, output logic [7:0] s, output logic [3:0] d, output logic f);
    int  digit;
    int  off;
    bit  dark;
    s = 8'h00; d = 4'h0; f = 1'b0;
    if (running) begin
      digit = t / SLOT;
      off   = t % SLOT;
      f     = (t == FRAME - 1);
      if (off < DW) begin
        d    = 4'(1 << digit);
        dark = act_bl[digit];
        if (lz && digit > 0 && (act_v >> (4 * digit)) == 16'h0) dark = 1'b1;
        if (!dark) s = GLYPH[act_v[4*digit +: 4]] | {7'b0, act_dp[digit]};
      end
    end
  endtask

  task automatic checkAll();
    logic [7:0] s; logic [3:0] d; logic f;
    expected(1'b0, s, d, f);
    checkOutput("seg", 32'(seg0), 32'(s));
    checkOutput("dig", 32'(dig0), 32'(d));
    checkOutput("frame_done", 32'(fd0), 32'(f));
    expected(1'b1, s, d, f);
    checkOutput("lz_seg", 32'(seg1), 32'(s));
    checkOutput("lz_dig", 32'(dig1), 32'(d));
    checkOutput("lz_frame_done", 32'(fd1), 32'(f));
  endtask

  task automatic tick();
    modelStep();
    @(posedge clk);
    @(negedge clk);
    checkAll();
  endtask

  task automatic waitPhase(input int target);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(running && t == target) && n < 200);
    checkOutput("wait_phase_bound", 32'(n < 200), 32'd1);
  endtask

  initial begin
    int pulses;
    int n;
    logic [15:0] rv;
    applyStimulus(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    #1 rst_n = 1'b0;
    modelReset();

    // Reset held with en high, then free-run two frames
    repeat (3) tick();
    rst_n = 1'b1;
    pulses = 0;
    repeat (2 * FRAME) begin
      tick();
      if (fd0) pulses++;
    end
    checkOutput("frame_pulses", 32'(pulses), 32'd2);

    // Basic display of 1234 loaded while off
    applyStimulus(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
    tick();
    applyStimulus(1'b0, 1'b1, 16'h1234, 4'h0, 4'h0);
    tick();
    applyStimulus(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    tick();
    checkOutput("basic_d0", 32'(seg0), 32'h66);
    waitPhase(6);
    checkOutput("basic_d1", 32'(seg0), 32'hF2);

    // Tear-free: load ABCD during digit 1
    applyStimulus(1'b1, 1'b1, 16'hABCD, 4'h0, 4'h0);
    tick();
    applyStimulus(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    waitPhase(12);
    checkOutput("tear_d2_old", 32'(seg0), 32'hDA);
    waitPhase(18);
    checkOutput("tear_d3_old", 32'(seg0), 32'h60);
    waitPhase(0);
    checkOutput("tear_d0_new", 32'(seg0), 32'h7A);
    waitPhase(18);
    checkOutput("tear_d3_new", 32'(seg0), 32'hEE);

    // Load in the frame_done cycle shows on the very next digit 0
    waitPhase(FRAME - 1);
    applyStimulus(1'b1, 1'b1, 16'h5678, 4'h0, 4'h0);
    tick();
    applyStimulus(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    checkOutput("bypass_d0", 32'(seg0), 32'hFE);

    // Blank and dp masks
    applyStimulus(1'b1, 1'b1, 16'h1234, 4'b0001, 4'b0100);
    tick();
    applyStimulus(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    waitPhase(0);
    checkOutput("mask_d0", 32'(seg0), 32'h67);
    waitPhase(12);
    checkOutput("mask_d2_seg", 32'(seg0), 32'h00);
    checkOutput("mask_d2_dig", 32'(dig0), 32'b0100);

    // Leading-zero suppression on dut_lz
    applyStimulus(1'b1, 1'b1, 16'h0050, 4'h0, 4'h0);
    tick();
    applyStimulus(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    waitPhase(0);
    checkOutput("lz_d0", 32'(seg1), 32'hFC);
    waitPhase(6);
    checkOutput("lz_d1", 32'(seg1), 32'hB6);
    waitPhase(12);
    checkOutput("lz_d2", 32'(seg1), 32'h00);
    waitPhase(18);
    checkOutput("lz_d3", 32'(seg1), 32'h00);
    applyStimulus(1'b1, 1'b1, 16'h0000, 4'h0, 4'h0);
    tick();
    applyStimulus(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    waitPhase(0);
    checkOutput("lz_zero_d0", 32'(seg1), 32'hFC);
    waitPhase(6);
    checkOutput("lz_zero_d1", 32'(seg1), 32'h00);

    // Abort during digit 2 gap, then restart with a full dwell
    waitPhase(2 * SLOT + DW);
    applyStimulus(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
    tick();
    checkOutput("abort_dig", 32'(dig0), 32'h0);
    applyStimulus(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    tick();
    n = 0;
    while (dig0 == 4'b0001 && n < 10) begin
      n++;
      tick();
    end
    checkOutput("restart_dwell", 32'(n), 32'd4);

    // Randomized loads, masks and enable drops against the model
    for (int i = 0; i < 400; i++) begin
      logic en_r;
      en_r = bus.en;
      if (bus.en && $urandom_range(0, 39) == 0) en_r = 1'b0;
      else if (!bus.en && $urandom_range(0, 3) == 0) en_r = 1'b1;
      rv = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 4)));
      applyStimulus(en_r, ($urandom_range(0, 7) == 0), rv, 4'($urandom),
                    ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
      tick();
    end

    // Asynchronous reset in the middle of SHOW
    applyStimulus(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    waitPhase(1);
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("async_rst_seg", 32'(seg0), 32'h0);
    checkOutput("async_rst_dig", 32'(dig0), 32'h0);
    checkOutput("async_rst_lz_dig", 32'(dig1), 32'h0);
    tick();
    rst_n = 1'b1;
    repeat (8) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan.md
Name: seg7_scan

Overview:
- Time-multiplexed scan controller for a bank of common-segment 7-segment digits.
- Holds a NUM_DIGITS-nibble display value and drives a single shared seg7 hex decoder one digit at a time.
- Each digit is shown for DWELL cycles, followed by an optional all-off GAP to suppress ghosting.
- Sits between the CPU/IO register that writes display values and the board segment/digit pins; value updates are tear-free and take effect only at frame boundaries.

Parameters:
- NUM_DIGITS, 4: number of digits scanned; legal range 1..8.
- DWELL, 1000: cycles each digit is lit; must be >= 1.
- GAP, 16: all-off cycles after each digit; 0 means no GAP state.
- LZ_SUPPRESS, 0: 1 = blank leading zero digits. Digit 0 is never suppressed.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  scan enable; low forces display off.
- load  in  1  one-cycle strobe that captures value/dp_in/blank_in.
- value  in  4*NUM_DIGITS  hex nibbles; digit i = value[4i+3:4i], digit 0 rightmost.
- dp_in  in  NUM_DIGITS  decimal point per digit (drives seg bit 0).
- blank_in  in  NUM_DIGITS  1 = digit i forced dark.
- seg  out  8  segments a..g,dp on bits 7..0, active-high.
- dig  out  NUM_DIGITS  one-hot digit enable, active-high.
- frame_done  out  1  one-cycle pulse at end of each frame.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. While rst_n = 0:
  - state = OFF, idx = 0, counter = 0.
  - active and pending registers = 0; pending_valid = 0.
  - seg = 0, dig = 0, frame_done = 0.
- States: OFF, SHOW, GAP.
  - OFF: dig = 0, seg = 0. If en = 1 at an edge: state goes to SHOW, idx = 0, counter = DWELL-1.
  - SHOW: lasts exactly DWELL cycles.
    - dig = one-hot(idx).
    - seg = decode(active nibble idx), with bit 0 = active dp[idx].
    - If the digit is blanked, seg = 0 and dig remains one-hot.
    - When the counter reaches 0: go to GAP with counter = GAP-1. If GAP = 0, advance the digit directly.
  - GAP: dig = 0, seg = 0, for exactly GAP cycles. At counter 0, advance the digit.
  - Advance: idx goes to idx+1, state goes to SHOW with counter = DWELL-1. When idx = NUM_DIGITS-1 it wraps to 0; this is the frame boundary.
- Frame timing:
  - Frame period = NUM_DIGITS*(DWELL+GAP) cycles.
  - frame_done is high during the final cycle of the frame (last digit's last GAP cycle, or last SHOW cycle if GAP = 0).
- Update rules:
  - load in OFF: value/dp_in/blank_in are written directly to active.
  - load in SHOW or GAP: the inputs are written to pending and pending_valid is set. A later load overwrites pending.
  - At the frame-boundary edge, pending is copied to active if pending_valid, and pending_valid is cleared.
  - A load in the frame_done cycle commits its own inputs (bypass), so they are visible on digit 0 of the next frame.
- Leading-zero suppression (LZ_SUPPRESS = 1):
  - Digit i > 0 is blanked if active nibbles i..NUM_DIGITS-1 are all zero.
  - Suppression is ORed with blank_in; dp is also suppressed on a blanked digit.
- en = 0 in SHOW or GAP:
  - At the next edge: state goes to OFF, idx = 0, no frame_done.
  - pending is retained and is committed on entry to OFF.
- Timing:
  - seg and dig are combinational decodes of registered state, idx and active only; there is no further latency and no path from inputs to outputs.
  - The counter is wide enough for max(DWELL, GAP).

Decomposition:
- Shared package seg7_scan_pkg holds:
  - the state enum (OFF, SHOW, GAP);
  - the SEG_OFF constant (8'h00);
  - a counter-width helper function.
- One sub-module: a single instance of the existing seg7 hex decoder, fed by the nibble mux. The dp OR and blank masking are applied after the decoder.

Test Plan (NUM_DIGITS=4, DWELL=4, GAP=2 unless stated):
- Reset and start:
  - Stimulus: rst_n held low with en = 1.
  - Response: seg = 0, dig = 0, frame_done = 0.
  - After release: dig = 4'b0001 for 4 cycles, then dig = 0 for 2 cycles, then 4'b0010.
  - frame_done pulses once every 24 cycles.
- Basic display:
  - Stimulus: en = 0, load value = 16'h1234, then en = 1.
  - Response: digit 0 seg = 8'b0110_0110, digit 1 = 8'b1111_0010, digit 2 = 8'b1101_1010, digit 3 = 8'b0110_0000.
- Tear-free update:
  - Stimulus: load 16'hABCD during digit 1 of a frame.
  - Response: digits 2 and 3 of that frame still show 2 and 1.
  - Next frame: digit 0 = 8'b0111_1010 (D) and digit 3 = 8'b1110_1110 (A).
  - Second case: load in the frame_done cycle appears on the very next digit 0.
- Masks:
  - Stimulus: value 16'h1234, blank_in = 4'b0100, dp_in = 4'b0001.
  - Response: digit 2 has seg = 0 with dig = 4'b0100; digit 0 seg = 8'b0110_0111.
- Leading-zero suppression:
  - Stimulus: LZ_SUPPRESS = 1, value 16'h0050.
  - Response: digits 3 and 2 have seg = 0; digit 1 = 8'b1011_0110; digit 0 = 8'b1111_1100.
  - Value 16'h0000: only digit 0 is lit (0).
- Abort and reset:
  - Stimulus: en = 0 during digit 2 GAP.
  - Response: next edge gives state OFF, outputs 0, no frame_done. Re-enable restarts at digit 0 with a full 4-cycle dwell.
  - Stimulus: rst_n asserted mid-SHOW.
  - Response: seg and dig go to 0 immediately, without waiting for a clock edge.
